regfile_access_ctrl: RTL
========================

Name: regfile_access_ctrl

Overview:
- Initiator side of the 3-bit-address, 16-bit-data register file interface (clk, we3, a1, a2, a3, wd3, rd1, rd2) in the multicycle datapath.
- Accepts one register-transfer request per instruction and drives the two read ports.
- Captures the operands and hands them to the ALU side with a valid/ready handshake.
- Waits for the ALU result, then performs a single-cycle write-back on port 3.
- The register file reads combinationally and writes on the rising edge of clk when we3=1.

Parameters:
DATA_W, 16, register data width
ADDR_W, 3, register address width (2**ADDR_W registers)
CNT_W, 8, width of retired-transaction counter

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  controller can accept request
req_rs1  in  ADDR_W  source register 1
req_rs2  in  ADDR_W  source register 2
req_rd  in  ADDR_W  destination register
req_wb_en  in  1  request needs write-back
opa  out  DATA_W  captured rd1 value
opb  out  DATA_W  captured rd2 value
op_valid  out  1  opa/opb valid
op_ready  in  1  ALU side accepts operands
res_valid  in  1  ALU result present
res_data  in  DATA_W  ALU result
res_ready  out  1  controller accepts result
rf_a1  out  ADDR_W  regfile read address 1
rf_a2  out  ADDR_W  regfile read address 2
rf_a3  out  ADDR_W  regfile write address
rf_wd3  out  DATA_W  regfile write data
rf_we3  out  1  regfile write enable
rf_rd1  in  DATA_W  regfile read data 1
rf_rd2  in  DATA_W  regfile read data 2
busy  out  1  state != IDLE
txn_cnt  out  CNT_W  completed write-backs, saturating

Behaviour:
- Clock and reset: clk is the only clock. Reset is synchronous and active-low: sampled on the rising edge of clk when rst_n=0.
- Reset values: state=IDLE. All registered outputs are 0: opa, opb, rf_a1, rf_a2, rf_a3, rf_wd3, rf_we3, txn_cnt, op_valid. Consequently req_ready=1 and res_ready=0.
- States: IDLE, READ, OPND, EXEC, WB. All outputs are registered or decoded directly from state.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready, latch rs1/rs2 into rf_a1/rf_a2, and latch rd and wb_en internally.
  - Go to READ.
- READ (exactly 1 cycle):
  - rf_a1/rf_a2 are stable.
  - At the end of the cycle, capture rf_rd1 into opa and rf_rd2 into opb, set op_valid=1, and go to OPND.
- OPND:
  - op_valid=1 and opa/opb are held until op_ready=1.
  - On handshake, op_valid drops next cycle and state goes to EXEC.
- EXEC:
  - res_ready=1.
  - On res_valid with wb_en=1: latch rf_wd3=res_data and rf_a3=rd, set rf_we3=1, and go to WB.
  - On res_valid with wb_en=0: go to IDLE. No write occurs and txn_cnt is unchanged.
  - res_valid outside EXEC is ignored (res_ready=0).
- WB (exactly 1 cycle):
  - rf_we3=1, and the regfile writes at the closing edge.
  - Next cycle rf_we3=0, txn_cnt increments (saturating at all-ones), and state returns to IDLE.
- Latency, request accept to write-back edge: 4 cycles minimum (READ, OPND with immediate op_ready, EXEC with immediate res_valid, WB).
- rf_a1, rf_a2, rf_a3 and rf_wd3 hold their last values outside their active states. rf_we3 is high only in WB.
- Read-after-write: the next request's READ is at least 1 cycle after the WB edge, so it reads the new value. No forwarding is required.
- Register 0: not special-cased. Writes to address 0 are issued like any other.
- Reset mid-operation: any state returns to IDLE on the same edge. rf_we3 and op_valid are forced low, so no partial write occurs. txn_cnt clears.
- req_valid while busy: ignored; the requester must hold it.

Decomposition:
- Shared package:
  - state encoding constants S_IDLE=0, S_READ=1, S_OPND=2, S_EXEC=3, S_WB=4 (3-bit)
  - DATA_W/ADDR_W defaults shared with regfile
- No sub-module. Single FSM plus datapath registers.
- The bench instantiates the existing regfile as the responder.

Test Plan:
- Reset, then preload r1=16'habcd, r2=16'h0123. Request rs1=1, rs2=2, rd=3, wb_en=1, with op_ready=1 and res_valid=1 with res_data=16'hcccc -> opa=abcd and opb=0123 after READ; rf_we3 high exactly 1 cycle with a3=3 and wd3=cccc; r3=cccc; txn_cnt=1.
- Back-to-back: write r1=16'h3333, then immediately request rs1=1 -> opa=3333, confirming read-after-write.
- Hold op_ready=0 for 5 cycles -> op_valid and opa/opb stable, state stays OPND, rf_we3=0. Pulse res_valid=1 during OPND -> ignored, and EXEC still waits for a fresh res_valid.
- wb_en=0 request -> rf_we3 never asserts, returns to IDLE after result, txn_cnt unchanged.
- rst_n=0 for one edge while in WB -> next cycle state=IDLE, rf_we3=0, txn_cnt=0, and the target register is unchanged if reset coincides with the WB edge, since rf_we3 is forced low that cycle.
- 260 write-back transactions -> txn_cnt saturates at 8'hff.

Source files
------------

// File: rtl/regfile_access_ctrl_pkg.sv
// Shared widths and FSM state encoding for the
// register-file access controller.
package regfile_access_ctrl_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int CNT_W  = 8;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_OPND = 3'd2,
    S_EXEC = 3'd3,
    S_WB   = 3'd4
  } state_t;

endpackage

// File: rtl/regfile_access_ctrl.sv
// Multicycle regfile initiator: read operands, hand
// them to the ALU, then write the result back on port 3.
module regfile_access_ctrl
  import regfile_access_ctrl_pkg::*;
#(
  parameter int DATA_W = regfile_access_ctrl_pkg::DATA_W,
  parameter int ADDR_W = regfile_access_ctrl_pkg::ADDR_W,
  parameter int CNT_W  = regfile_access_ctrl_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_rs1,
  input  logic [ADDR_W-1:0] req_rs2,
  input  logic [ADDR_W-1:0] req_rd,
  input  logic              req_wb_en,
  output logic [DATA_W-1:0] opa,
  output logic [DATA_W-1:0] opb,
  output logic              op_valid,
  input  logic              op_ready,
  input  logic              res_valid,
  input  logic [DATA_W-1:0] res_data,
  output logic              res_ready,
  output logic [ADDR_W-1:0] rf_a1,
  output logic [ADDR_W-1:0] rf_a2,
  output logic [ADDR_W-1:0] rf_a3,
  output logic [DATA_W-1:0] rf_wd3,
  output logic              rf_we3,
  input  logic [DATA_W-1:0] rf_rd1,
  input  logic [DATA_W-1:0] rf_rd2,
  output logic              busy,
  output logic [CNT_W-1:0]  txn_cnt
);

  state_t            r_state;
  logic [ADDR_W-1:0] r_a1;
  logic [ADDR_W-1:0] r_a2;
  logic [ADDR_W-1:0] r_a3;
  logic [ADDR_W-1:0] r_rd;
  logic              r_wb_en;
  logic [DATA_W-1:0] r_wd3;
  logic              r_we3;
  logic [DATA_W-1:0] r_opa;
  logic [DATA_W-1:0] r_opb;
  logic              r_op_valid;
  logic [CNT_W-1:0]  r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_a1       <= '0;
      r_a2       <= '0;
      r_a3       <= '0;
      r_rd       <= '0;
      r_wb_en    <= 1'b0;
      r_wd3      <= '0;
      r_we3      <= 1'b0;
      r_opa      <= '0;
      r_opb      <= '0;
      r_op_valid <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_we3 <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_a1    <= req_rs1;
            r_a2    <= req_rs2;
            r_rd    <= req_rd;
            r_wb_en <= req_wb_en;
            r_state <= S_READ;
          end
        end
        S_READ: begin
          r_opa      <= rf_rd1;
          r_opb      <= rf_rd2;
          r_op_valid <= 1'b1;
          r_state    <= S_OPND;
        end
        S_OPND: begin
          if (op_ready) begin
            r_op_valid <= 1'b0;
            r_state    <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (res_valid) begin
            if (r_wb_en) begin
              r_wd3   <= res_data;
              r_a3    <= r_rd;
              r_we3   <= 1'b1;
              r_state <= S_WB;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_WB: begin
          if (r_cnt != {CNT_W{1'b1}})
            r_cnt <= r_cnt + 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready = (r_state == S_IDLE);
  assign res_ready = (r_state == S_EXEC);
  assign busy      = (r_state != S_IDLE);
  assign opa       = r_opa;
  assign opb       = r_opb;
  assign op_valid  = r_op_valid;
  assign rf_a1     = r_a1;
  assign rf_a2     = r_a2;
  assign rf_a3     = r_a3;
  assign rf_wd3    = r_wd3;
  assign txn_cnt   = r_cnt;
  // A reset landing on the WB closing edge must not commit the write.
  assign rf_we3    = r_we3 & rst_n;

endmodule
